// File: rtl/keys_event_poller.sv
// Avalon-MM master that polls a KEYS PIO edge-capture register on a fixed period and
// queues timestamped key events in a first-word-fall-through FIFO.
module keys_event_poller #(
    parameter int unsigned POLL_DIV   = 50000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        ev_valid,
    output logic [23:0] ev_data,
    input  logic        ev_ready,
    output logic        irq,
    output logic        overflow,
    input  logic        clr_overflow
);

    localparam int unsigned TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] TimerReload = TW'(POLL_DIV - 1);
    localparam logic [AW:0]   FifoFull    = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StRdEdge  = 3'd1;
    localparam logic [2:0] StClrEdge = 3'd2;
    localparam logic [2:0] StRdData  = 3'd3;
    localparam logic [2:0] StPush    = 3'd4;

    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   ts_q, ts_d;
    logic          pending_q, pending_d;
    logic [2:0]    state_q, state_d;
    logic [15:0]   stamp_q, stamp_d;
    logic [3:0]    edges_q, edges_d;
    logic [3:0]    levels_q, levels_d;
    logic          overflow_q, overflow_d;

    logic [23:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    logic tick;
    logic full;
    logic pop;
    logic push_req;
    logic push;
    logic drop;
    logic unused_rdata;

    assign unused_rdata = ^m_readdata[31:4];

    assign tick     = (timer_q == '0);
    assign full     = (count_q == FifoFull);
    assign ev_valid = (count_q != '0);
    assign irq      = ev_valid;
    assign overflow = overflow_q;
    assign ev_data  = ev_valid ? mem_q[rptr_q] : 24'd0;
    assign pop      = ev_valid & ev_ready;
    assign push_req = (state_q == StPush);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        timer_d = tick ? TimerReload : timer_q - TW'(1);
        ts_d    = tick ? ts_q + 16'd1 : ts_q;
    end

    always_comb begin
        state_d   = state_q;
        stamp_d   = stamp_q;
        edges_d   = edges_q;
        levels_d  = levels_q;
        pending_d = pending_q;
        if (state_q == StIdle && pending_q) begin
            pending_d = 1'b0;
        end
        if (tick) begin
            pending_d = 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (pending_q) begin
                    // The counter has already advanced past the tick that raised pending.
                    stamp_d = ts_q - 16'd1;
                    state_d = StRdEdge;
                end
            end
            StRdEdge: begin
                if (!m_waitrequest) begin
                    edges_d = m_readdata[3:0];
                    state_d = (m_readdata[3:0] == 4'd0) ? StIdle : StClrEdge;
                end
            end
            StClrEdge: begin
                if (!m_waitrequest) begin
                    state_d = StRdData;
                end
            end
            StRdData: begin
                if (!m_waitrequest) begin
                    levels_d = m_readdata[3:0];
                    state_d  = StPush;
                end
            end
            StPush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        m_address   = 2'd0;
        m_read      = 1'b0;
        m_write     = 1'b0;
        m_writedata = 32'd0;
        case (state_q)
            StRdEdge: begin
                m_address = 2'd3;
                m_read    = 1'b1;
            end
            StClrEdge: begin
                m_address   = 2'd3;
                m_write     = 1'b1;
                m_writedata = 32'h0000_000F;
            end
            StRdData: begin
                m_read = 1'b1;
            end
            default: begin
                m_read = 1'b0;
            end
        endcase
    end

    always_comb begin
        wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push && !pop) begin
            count_d = count_q + {{AW{1'b0}}, 1'b1};
        end else if (pop && !push) begin
            count_d = count_q - {{AW{1'b0}}, 1'b1};
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q    <= TimerReload;
            ts_q       <= 16'd0;
            pending_q  <= 1'b0;
            state_q    <= StIdle;
            stamp_q    <= 16'd0;
            edges_q    <= 4'd0;
            levels_q   <= 4'd0;
            overflow_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            timer_q    <= timer_d;
            ts_q       <= ts_d;
            pending_q  <= pending_d;
            state_q    <= state_d;
            stamp_q    <= stamp_d;
            edges_q    <= edges_d;
            levels_q   <= levels_d;
            overflow_q <= overflow_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {stamp_q, levels_q, edges_q};
        end
    end

endmodule

// File: tb/tb_keys_event_poller.sv
// Directed bench for keys_event_poller: empty polls, event latency, stalls, overflow,
// full-FIFO push/pop and reset during a stalled read.
module tb_keys_event_poller;

    logic        clk;
    logic        reset;
    logic [1:0]  m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic        ev_valid;
    logic [23:0] ev_data;
    logic        ev_ready;
    logic        irq;
    logic        overflow;
    logic        clr_overflow;

    logic [3:0]  edge_val;
    logic [3:0]  lvl_val;
    int          n_cmp;
    int          n_err;
    int          ncnt;

    keys_event_poller #(
        .POLL_DIV  (8),
        .FIFO_DEPTH(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m_address    (m_address),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .m_waitrequest(m_waitrequest),
        .ev_valid     (ev_valid),
        .ev_data      (ev_data),
        .ev_ready     (ev_ready),
        .irq          (irq),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    // Minimal PIO: address 3 is edge_capture, anything else the live levels.
    assign m_readdata = (m_address == 2'd3) ? {28'd0, edge_val} : {28'd0, lvl_val};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
        ncnt++;
    endtask

    task automatic goto(input int k);
        while (ncnt < k) next();
    endtask

    // Leaves the bench at the releasing negedge, numbered cycle 0.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ncnt  = 0;
    endtask

    initial begin
        int  nwr;
        logic saw_valid;
        n_cmp         = 0;
        n_err         = 0;
        ncnt          = 0;
        reset         = 1'b1;
        m_waitrequest = 1'b0;
        ev_ready      = 1'b0;
        clr_overflow  = 1'b0;
        edge_val      = 4'd0;
        lvl_val       = 4'd0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_m_read", {31'd0, m_read}, 32'd0);
        chk("rst_m_write", {31'd0, m_write}, 32'd0);
        chk("rst_m_address", {30'd0, m_address}, 32'd0);
        chk("rst_m_writedata", m_writedata, 32'd0);
        chk("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_ev_data", {8'd0, ev_data}, 32'd0);

        // Empty polls: reads at cycles 9, 17, 25 only
        do_reset();
        nwr       = 0;
        saw_valid = 1'b0;
        for (int i = 1; i <= 26; i++) begin
            next();
            chk("empty_poll_read", {31'd0, m_read}, (i == 9 || i == 17 || i == 25) ? 32'd1 : 32'd0);
            if (m_read) chk("empty_poll_addr", {30'd0, m_address}, 32'd3);
            if (m_write) nwr++;
            if (ev_valid) saw_valid = 1'b1;
        end
        chk("empty_poll_writes", nwr, 32'd0);
        chk("empty_poll_valid", {31'd0, saw_valid}, 32'd0);

        // Second tick carries edge 0x2, levels 0x2
        do_reset();
        lvl_val = 4'h2;
        goto(10);
        edge_val = 4'h2;
        goto(17);
        chk("ev_rd_edge_read", {31'd0, m_read}, 32'd1);
        chk("ev_rd_edge_addr", {30'd0, m_address}, 32'd3);
        next();
        chk("ev_clr_write", {31'd0, m_write}, 32'd1);
        chk("ev_clr_read", {31'd0, m_read}, 32'd0);
        chk("ev_clr_addr", {30'd0, m_address}, 32'd3);
        chk("ev_clr_wdata", m_writedata, 32'h0000_000F);
        next();
        edge_val = 4'h0;
        chk("ev_rd_data_read", {31'd0, m_read}, 32'd1);
        chk("ev_rd_data_addr", {30'd0, m_address}, 32'd0);
        chk("ev_rd_data_wdata", m_writedata, 32'd0);
        next();
        chk("ev_push_valid", {31'd0, ev_valid}, 32'd0);
        chk("ev_push_bus", {30'd0, m_read, m_write}, 32'd0);
        next();
        chk("ev_valid", {31'd0, ev_valid}, 32'd1);
        chk("ev_irq", {31'd0, irq}, 32'd1);
        chk("ev_data", {8'd0, ev_data}, 32'h0000_0122);
        ev_ready = 1'b1;
        next();
        ev_ready = 1'b0;
        chk("ev_pop_empty", {31'd0, ev_valid}, 32'd0);
        chk("ev_pop_irq", {31'd0, irq}, 32'd0);

        // Three stall cycles during CLR_EDGE
        do_reset();
        edge_val = 4'h2;
        lvl_val  = 4'h5;
        goto(10);
        m_waitrequest = 1'b1;
        for (int i = 10; i <= 13; i++) begin
            if (i == 13) m_waitrequest = 1'b0;
            chk("stall_write", {31'd0, m_write}, 32'd1);
            chk("stall_addr", {30'd0, m_address}, 32'd3);
            chk("stall_wdata", m_writedata, 32'h0000_000F);
            next();
        end
        edge_val = 4'h0;
        chk("stall_rd_data", {31'd0, m_read}, 32'd1);
        chk("stall_rd_data_addr", {30'd0, m_address}, 32'd0);
        next();
        chk("stall_push_valid", {31'd0, ev_valid}, 32'd0);
        next();
        chk("stall_ev_valid", {31'd0, ev_valid}, 32'd1);
        chk("stall_ev_data", {8'd0, ev_data}, 32'h0000_0052);
        ev_ready = 1'b1;
        next();
        ev_ready = 1'b0;
        chk("stall_pop_empty", {31'd0, ev_valid}, 32'd0);

        // Overflow with a 2-entry FIFO, then full push with same-cycle pop
        do_reset();
        edge_val = 4'h1;
        lvl_val  = 4'h3;
        goto(13);
        chk("ovf_first_valid", {31'd0, ev_valid}, 32'd1);
        chk("ovf_first_data", {8'd0, ev_data}, 32'h0000_0031);
        goto(28);
        chk("ovf_before_drop", {31'd0, overflow}, 32'd0);
        next();
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_head_kept", {8'd0, ev_data}, 32'h0000_0031);
        clr_overflow = 1'b1;
        next();
        clr_overflow = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        ev_ready = 1'b1;
        next();
        ev_ready = 1'b0;
        chk("ovf_second_valid", {31'd0, ev_valid}, 32'd1);
        chk("ovf_second_data", {8'd0, ev_data}, 32'h0000_0131);
        goto(44);
        ev_ready = 1'b1;
        next();
        chk("full_pp_overflow", {31'd0, overflow}, 32'd0);
        chk("full_pp_data0", {8'd0, ev_data}, 32'h0000_0331);
        next();
        chk("full_pp_data1", {8'd0, ev_data}, 32'h0000_0431);
        chk("full_pp_valid1", {31'd0, ev_valid}, 32'd1);
        next();
        ev_ready = 1'b0;
        chk("full_pp_drained", {31'd0, ev_valid}, 32'd0);

        // Reset asserted while RD_DATA is stalled
        do_reset();
        edge_val = 4'h1;
        lvl_val  = 4'h6;
        goto(19);
        m_waitrequest = 1'b1;
        next();
        chk("rst_mid_read_before", {31'd0, m_read}, 32'd1);
        chk("rst_mid_valid_before", {31'd0, ev_valid}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_read", {31'd0, m_read}, 32'd0);
        chk("rst_mid_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_mid_addr", {30'd0, m_address}, 32'd0);
        @(negedge clk);
        m_waitrequest = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ncnt  = 0;
        goto(8);
        chk("rst_mid_no_early_read", {31'd0, m_read}, 32'd0);
        next();
        chk("rst_mid_first_read", {31'd0, m_read}, 32'd1);
        chk("rst_mid_first_addr", {30'd0, m_address}, 32'd3);
        goto(13);
        chk("rst_mid_ev_valid", {31'd0, ev_valid}, 32'd1);
        chk("rst_mid_ev_data", {8'd0, ev_data}, 32'h0000_0061);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
